uart_ctrl: RTL and testbench
============================

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning entries per TX and RX FIFO (power of 2, at least 2).
REQ-002 SHALL have port CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports ADDR in 3 (word offset), WDATA in 32, WE in 1, RE in 1 and RDATA out 32, forming the MIPS memory-mapped bus.
REQ-005 SHALL have ports TX_P_DATA out 8, TX_DATA_VALID out 1 and TX_BUSY in 1 to the UART transmitter.
REQ-006 SHALL have ports RX_P_DATA in 8, RX_DATA_VALID in 1 (one-CLK pulse, already in the CLK domain), PAR_ERR in 1 and STP_ERR in 1 from the UART receiver.
REQ-007 SHALL have ports PAR_EN out 1, PAR_TYP out 1 (0 = EVEN, 1 = ODD) and PRESCALE out 6 as UART configuration.
REQ-008 SHALL have port IRQ out 1, a level interrupt to the core.

Function
REQ-009 SHALL decode the register map by ADDR:
- 0 CONFIG (r/w): [0] PAR_EN, [1] PAR_TYP, [7:2] PRESCALE.
- 1 TXDATA (w): push WDATA[7:0].
- 2 RXDATA (r): {22'b0, stp, par, data[7:0]}; RE pops.
- 3 STATUS (r, write-1-to-clear on bits 4-7): [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] tx_ovf, [5] rx_ovr, [6] par_err, [7] stp_err.
- 4 IRQ_EN (r/w): [0] rx_not_empty, [1] tx_empty, [2] any error.
REQ-010 SHALL drive RDATA combinationally from ADDR every cycle; unmapped addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-011 SHALL update CONFIG and IRQ_EN on the CLK edge where WE is 1; PAR_EN, PAR_TYP and PRESCALE SHALL reflect the new value the cycle after.
REQ-012 SHALL accept a TXDATA write if the TX FIFO is not full, or if it is full and a pop occurs in the same cycle; otherwise it SHALL drop the byte and set tx_ovf.
REQ-013 SHALL run the TX FSM with states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
- IDLE -> ISSUE when the TX FIFO is not empty and TX_BUSY is 0.
- ISSUE (one cycle): TX_DATA_VALID = 1, TX_P_DATA = FIFO head, FIFO pops; -> WAIT_BUSY.
- WAIT_BUSY -> WAIT_DONE when TX_BUSY is 1.
- WAIT_DONE -> IDLE when TX_BUSY is 0.
REQ-014 SHALL hold TX_DATA_VALID at 0 outside ISSUE, and hold TX_P_DATA stable at the last issued byte.
REQ-015 SHALL push {STP_ERR, PAR_ERR, RX_P_DATA} into the RX FIFO on RX_DATA_VALID; bytes with errors SHALL still be stored.
REQ-016 SHALL drop an incoming RX byte when the RX FIFO is full and no pop occurs in the same cycle, and set rx_ovr; a simultaneous pop and push on a full FIFO SHALL keep it full with no loss.
REQ-017 SHALL set par_err or stp_err when a byte arrives with the corresponding flag set, whether the byte is stored or dropped.
REQ-018 SHALL pop the RX FIFO only on RE with ADDR = 2 while not empty; a read when empty SHALL return 0 and not change pointers.
REQ-019 SHALL, on a write-1-to-clear coinciding with a set event for the same sticky bit, let the set win.
REQ-020 SHALL use pointers one bit wider than log2(FIFO_DEPTH) so that wrap-around distinguishes full from empty.
REQ-021 SHALL drive IRQ = (IRQ_EN[0] & !rx_empty) | (IRQ_EN[1] & tx_empty & TX FSM in IDLE) | (IRQ_EN[2] & |STATUS[7:4]), registered with one-cycle latency.

Reset
REQ-022 SHALL, while RESET is 1 and regardless of CLK, set:
- FIFOs empty, TX FSM in IDLE, all sticky bits and IRQ_EN cleared;
- PAR_EN = 0, PAR_TYP = 0, PRESCALE = 8;
- TX_DATA_VALID = 0, TX_P_DATA = 0, IRQ = 0.
REQ-023 SHALL, on RESET asserted mid-transmission, abandon the FSM and discard queued bytes; no TX_DATA_VALID SHALL follow the release of reset until a new byte is written.

Verification
REQ-024 SHALL be verified: write CONFIG = 0x23 -> next cycle PAR_EN = 1, PAR_TYP = 1, PRESCALE = 8; read CONFIG returns 0x23.
REQ-025 SHALL be verified: write TXDATA 0x4D, 0xA5 with TX_BUSY modeled at 10 cycles -> two ISSUE pulses carrying 0x4D then 0xA5, the second no earlier than TX_BUSY falling; tx_empty = 1 at the end.
REQ-026 SHALL be verified: with TX_BUSY held at 1, write 5 bytes at FIFO_DEPTH = 4 -> the 5th is dropped, tx_ovf = 1, tx_full = 1; writing 0x10 to STATUS clears tx_ovf.
REQ-027 SHALL be verified: inject 5 RX bytes 0x01-0x05 without reads -> rx_full = 1, rx_ovr = 1, and reads return 0x01-0x04, then 0.
REQ-028 SHALL be verified: inject RX byte 0x4D with PAR_ERR = 1 and IRQ_EN = 0x5 -> RXDATA = 0x14D, par_err = 1, IRQ = 1 one cycle after the push.
REQ-029 SHALL be verified: assert RESET during WAIT_DONE with 2 bytes queued -> all outputs at reset values immediately, no later TX_DATA_VALID.

Source files
------------

// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped UART controller with TX/RX FIFOs and IRQ.
// Bus: ADDR/WDATA/WE/RE/RDATA; TX: TX_P_DATA/TX_DATA_VALID/TX_BUSY;
// RX: RX_P_DATA/RX_DATA_VALID/PAR_ERR/STP_ERR; cfg: PAR_EN/PAR_TYP/PRESCALE.
module uart_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  ADDR,
  input  logic [31:0] WDATA,
  input  logic        WE,
  input  logic        RE,
  output logic [31:0] RDATA,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_DATA_VALID,
  input  logic        TX_BUSY,
  input  logic [7:0]  RX_P_DATA,
  input  logic        RX_DATA_VALID,
  input  logic        PAR_ERR,
  input  logic        STP_ERR,
  output logic        PAR_EN,
  output logic        PAR_TYP,
  output logic [5:0]  PRESCALE,
  output logic        IRQ
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_st_t;

  tx_st_t      r_state;
  logic [7:0]  r_cfg;
  logic [2:0]  r_ien;
  logic        r_tx_ovf;
  logic        r_rx_ovr;
  logic        r_par_err;
  logic        r_stp_err;
  logic        r_irq;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [9:0]  r_rx_mem [FIFO_DEPTH];
  logic [AW:0] r_tx_wp;
  logic [AW:0] r_tx_rp;
  logic [AW:0] r_rx_wp;
  logic [AW:0] r_rx_rp;

  logic        w_sel_cfg;
  logic        w_sel_tx;
  logic        w_sel_rx;
  logic        w_sel_st;
  logic        w_sel_ien;
  logic        w_tx_empty;
  logic        w_tx_full;
  logic        w_rx_empty;
  logic        w_rx_full;
  logic        w_tx_wr;
  logic        w_tx_pop;
  logic        w_tx_push;
  logic        w_tx_drop;
  logic        w_rx_pop;
  logic        w_rx_push;
  logic        w_rx_drop;
  logic [3:0]  w_clr;
  logic [7:0]  w_tx_head;
  logic [9:0]  w_rx_head;
  logic [7:0]  w_status;
  logic        w_unused;

  assign w_unused = ^WDATA[31:8];

  assign w_sel_cfg = (ADDR == 3'd0);
  assign w_sel_tx  = (ADDR == 3'd1);
  assign w_sel_rx  = (ADDR == 3'd2);
  assign w_sel_st  = (ADDR == 3'd3);
  assign w_sel_ien = (ADDR == 3'd4);

  // Extra MSB on pointers: equal MSB means empty, differing MSB means full.
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) &&
                      (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) &&
                      (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);

  assign w_tx_head = r_tx_mem[r_tx_rp[AW-1:0]];
  assign w_rx_head = r_rx_mem[r_rx_rp[AW-1:0]];

  // A pop in the same cycle frees the slot a full-FIFO push lands in.
  assign w_tx_wr   = WE & w_sel_tx;
  assign w_tx_pop  = (r_state == S_ISSUE);
  assign w_tx_push = w_tx_wr & (~w_tx_full | w_tx_pop);
  assign w_tx_drop = w_tx_wr & ~w_tx_push;

  assign w_rx_pop  = RE & w_sel_rx & ~w_rx_empty;
  assign w_rx_push = RX_DATA_VALID & (~w_rx_full | w_rx_pop);
  assign w_rx_drop = RX_DATA_VALID & ~w_rx_push;

  assign w_clr = (WE & w_sel_st) ? WDATA[7:4] : 4'b0;

  assign w_status = {r_stp_err, r_par_err, r_rx_ovr, r_tx_ovf,
                     w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};

  always_comb begin
    RDATA = 32'b0;
    case (ADDR)
      3'd0:    RDATA = {24'b0, r_cfg};
      3'd2:    RDATA = w_rx_empty ? 32'b0 : {22'b0, w_rx_head};
      3'd3:    RDATA = {24'b0, w_status};
      3'd4:    RDATA = {29'b0, r_ien};
      default: RDATA = 32'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= WDATA[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <=
      {STP_ERR, PAR_ERR, RX_P_DATA};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
    end
  end

  // Sticky bits: a set event in the same cycle overrides the clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cfg     <= 8'h20;
      r_ien     <= 3'b0;
      r_tx_ovf  <= 1'b0;
      r_rx_ovr  <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (WE & w_sel_cfg) r_cfg <= WDATA[7:0];
      if (WE & w_sel_ien) r_ien <= WDATA[2:0];
      r_tx_ovf  <= w_tx_drop | (r_tx_ovf & ~w_clr[0]);
      r_rx_ovr  <= w_rx_drop | (r_rx_ovr & ~w_clr[1]);
      r_par_err <= (RX_DATA_VALID & PAR_ERR) |
                   (r_par_err & ~w_clr[2]);
      r_stp_err <= (RX_DATA_VALID & STP_ERR) |
                   (r_stp_err & ~w_clr[3]);
      r_irq <= (r_ien[0] & ~w_rx_empty) |
               (r_ien[1] & w_tx_empty & (r_state == S_IDLE)) |
               (r_ien[2] & |w_status[7:4]);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_tx_empty && !TX_BUSY) begin
            r_state    <= S_ISSUE;
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_tx_head;
          end
        end
        S_ISSUE: begin
          r_state    <= S_WAIT_BUSY;
          r_tx_valid <= 1'b0;
        end
        S_WAIT_BUSY: begin
          if (TX_BUSY) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!TX_BUSY) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign TX_P_DATA     = r_tx_data;
  assign TX_DATA_VALID = r_tx_valid;
  assign PAR_EN        = r_cfg[0];
  assign PAR_TYP       = r_cfg[1];
  assign PRESCALE      = r_cfg[7:2];
  assign IRQ           = r_irq;

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed + randomized checks of uart_ctrl against a
// queue-based model of the FIFOs, sticky flags and transmitter timing.
module tb_uart_ctrl;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [2:0]  ADDR;
  logic [31:0] WDATA;
  logic        WE;
  logic        RE;
  logic [31:0] RDATA;
  logic [7:0]  TX_P_DATA;
  logic        TX_DATA_VALID;
  logic        TX_BUSY;
  logic [7:0]  RX_P_DATA;
  logic        RX_DATA_VALID;
  logic        PAR_ERR;
  logic        STP_ERR;
  logic        PAR_EN;
  logic        PAR_TYP;
  logic [5:0]  PRESCALE;
  logic        IRQ;

  uart_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .WDATA(WDATA),
    .WE(WE), .RE(RE), .RDATA(RDATA),
    .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
    .TX_BUSY(TX_BUSY), .RX_P_DATA(RX_P_DATA),
    .RX_DATA_VALID(RX_DATA_VALID), .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .PRESCALE(PRESCALE), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  int n_run = 0;
  int n_fail = 0;

  // Transmitter model: busy for 10 cycles after each accepted byte.
  logic       hold_busy;
  int         busy_cnt;
  int         cyc;
  logic [7:0] tx_seen[$];
  int         issue_q[$];
  int         fall_q[$];

  assign TX_BUSY = hold_busy | (busy_cnt != 0);

  always @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      busy_cnt = 0;
    end else begin
      cyc = cyc + 1;
      if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
        if (busy_cnt == 0) fall_q.push_back(cyc);
      end else if (TX_DATA_VALID) begin
        busy_cnt = 10;
      end
      if (TX_DATA_VALID) begin
        tx_seen.push_back(TX_P_DATA);
        issue_q.push_back(cyc);
      end
    end
  end

  logic [9:0] m_rx[$];
  logic [7:0] m_tx[$];
  logic m_txovf, m_rxovr, m_par, m_stp;

  function automatic logic [31:0] exp_status();
    return {24'b0, m_stp, m_par, m_rxovr, m_txovf,
            m_rx.size() == DEPTH, m_rx.size() == 0,
            m_tx.size() == 0, m_tx.size() == DEPTH};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    ADDR = a; WDATA = d; WE = 1'b1;
    @(negedge CLK);
    WE = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic pop,
                    output logic [31:0] d);
    ADDR = a; RE = pop;
    #1 d = RDATA;
    @(negedge CLK);
    RE = 1'b0;
  endtask

  task automatic rx_in(input logic [7:0] b, input logic pe,
                       input logic se);
    RX_P_DATA = b; PAR_ERR = pe; STP_ERR = se; RX_DATA_VALID = 1'b1;
    @(negedge CLK);
    RX_DATA_VALID = 1'b0; PAR_ERR = 1'b0; STP_ERR = 1'b0;
  endtask

  function automatic void m_rx_push(input logic [7:0] b,
                                    input logic pe, input logic se);
    if (m_rx.size() < DEPTH) m_rx.push_back({se, pe, b});
    else m_rxovr = 1'b1;
    if (pe) m_par = 1'b1;
    if (se) m_stp = 1'b1;
  endfunction

  function automatic logic [31:0] m_rx_pop();
    if (m_rx.size() == 0) return 32'b0;
    return {22'b0, m_rx.pop_front()};
  endfunction

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_seen.size() < n && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check("tx_issue_count", tx_seen.size(), n);
  endtask

  task automatic clear_seen();
    tx_seen.delete();
    issue_q.delete();
    fall_q.delete();
  endtask

  logic [31:0] d;
  logic [31:0] v;
  logic [7:0]  b;
  logic [7:0]  exp_tx[$];

  initial begin
    RESET = 1'b1; ADDR = '0; WDATA = '0; WE = 0; RE = 0;
    RX_P_DATA = '0; RX_DATA_VALID = 0; PAR_ERR = 0; STP_ERR = 0;
    hold_busy = 0; busy_cnt = 0; cyc = 0;
    m_txovf = 0; m_rxovr = 0; m_par = 0; m_stp = 0;

    // Reset values, before any clock edge.
    #1;
    check("rst_txv", TX_DATA_VALID, 0);
    check("rst_txd", TX_P_DATA, 0);
    check("rst_irq", IRQ, 0);
    check("rst_paren", PAR_EN, 0);
    check("rst_partyp", PAR_TYP, 0);
    check("rst_prescale", PRESCALE, 8);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    rd(0, 0, d); check("rst_cfg", d, 32'h20);
    rd(3, 0, d); check("rst_status", d, exp_status());
    rd(4, 0, d); check("rst_ien", d, 0);
    rd(2, 1, d); check("rst_rx_empty", d, 0);

    // CONFIG
    wr(0, 32'h23);
    check("cfg_paren", PAR_EN, 1);
    check("cfg_partyp", PAR_TYP, 1);
    check("cfg_prescale", PRESCALE, 8);
    rd(0, 0, d); check("cfg_read", d, 32'h23);
    v = {24'b0, 8'($urandom)};
    wr(0, v);
    check("cfg_rnd_prescale", PRESCALE, v[7:2]);
    check("cfg_rnd_paren", PAR_EN, v[0]);
    wr(5, $urandom);
    wr(7, $urandom);
    rd(5, 0, d); check("unmapped5", d, 0);
    rd(7, 0, d); check("unmapped7", d, 0);
    rd(1, 0, d); check("txdata_wo", d, 0);
    rd(0, 0, d); check("cfg_kept", d, v);

    // TX: two directed bytes then two random ones.
    clear_seen();
    exp_tx = {8'h4D, 8'hA5, 8'($urandom), 8'($urandom)};
    foreach (exp_tx[i]) wr(1, {24'b0, exp_tx[i]});
    wait_tx(4, 200);
    foreach (exp_tx[i]) check("tx_byte", tx_seen[i], exp_tx[i]);
    check("tx_gap", issue_q[1] > fall_q[0], 1);
    check("tx_gap2", issue_q[3] > fall_q[2], 1);
    repeat (15) tick();
    rd(3, 0, d); check("tx_empty_end", d, exp_status());

    // TX overflow with the transmitter stuck busy.
    hold_busy = 1'b1;
    tick();
    clear_seen();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      wr(1, {24'b0, b});
      if (m_tx.size() < DEPTH) m_tx.push_back(b);
      else m_txovf = 1'b1;
    end
    rd(3, 0, d); check("tx_ovf_status", d, exp_status());
    check("tx_held", tx_seen.size(), 0);
    wr(3, 32'h10);
    m_txovf = 1'b0;
    rd(3, 0, d); check("tx_ovf_clr", d, exp_status());
    hold_busy = 1'b0;
    wait_tx(DEPTH, 400);
    for (int i = 0; i < DEPTH; i++)
      check("tx_held_byte", tx_seen[i], m_tx[i]);
    m_tx.delete();
    repeat (15) tick();
    rd(3, 0, d); check("tx_drained", d, exp_status());

    // RX overrun: 1..5 with no reads.
    for (int i = 1; i <= 5; i++) begin
      rx_in(8'(i), 0, 0);
      m_rx_push(8'(i), 0, 0);
    end
    rd(3, 0, d); check("rx_ovr_status", d, exp_status());
    for (int i = 0; i < 5; i++) begin
      v = m_rx_pop();
      rd(2, 1, d); check("rx_ovr_read", d, v);
    end
    wr(3, 32'h20);
    m_rxovr = 1'b0;

    // Push and pop together on a full FIFO keeps it full, no loss.
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      rx_in(b, 0, 0);
      m_rx_push(b, 0, 0);
    end
    b = 8'($urandom);
    ADDR = 3'd2; RE = 1'b1;
    RX_P_DATA = b; RX_DATA_VALID = 1'b1;
    #1 d = RDATA;
    @(negedge CLK);
    RE = 1'b0; RX_DATA_VALID = 1'b0;
    check("rx_full_popush", d, m_rx_pop());
    m_rx_push(b, 0, 0);
    rd(3, 0, d); check("rx_full_kept", d, exp_status());

    // Random mix of arrivals (with errors) and reads.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic pe, se;
        b = 8'($urandom);
        pe = ($urandom_range(0, 3) == 0);
        se = ($urandom_range(0, 3) == 0);
        rx_in(b, pe, se);
        m_rx_push(b, pe, se);
      end else begin
        v = m_rx_pop();
        rd(2, 1, d); check("rx_rnd_read", d, v);
      end
    end
    rd(3, 0, d); check("rx_rnd_status", d, exp_status());
    while (m_rx.size() > 0) begin
      v = m_rx_pop();
      rd(2, 1, d); check("rx_drain", d, v);
    end

    // Parity error byte with IRQ_EN = 5.
    wr(3, 32'hF0);
    m_rxovr = 0; m_txovf = 0; m_par = 0; m_stp = 0;
    wr(4, 32'h5);
    rx_in(8'h4D, 1, 0);
    m_rx_push(8'h4D, 1, 0);
    check("irq_not_yet", IRQ, 0);
    rd(2, 0, d); check("rx_par_data", d, 32'h14D);
    check("irq_after_push", IRQ, 1);
    rd(3, 0, d); check("rx_par_status", d, exp_status());
    v = m_rx_pop();
    rd(2, 1, d); check("rx_par_pop", d, v);
    wr(4, 32'h2);
    tick();
    check("irq_tx_empty", IRQ, 1);

    // Reset while the transmitter is mid-byte with 2 bytes queued.
    wr(3, 32'hF0);
    m_par = 0;
    wr(0, 32'h23);
    wr(4, 32'h1);
    rx_in(8'($urandom), 0, 1);
    tick();
    check("irq_pre_rst", IRQ, 1);
    clear_seen();
    for (int i = 0; i < 3; i++) wr(1, 32'($urandom_range(1, 255)));
    wait_tx(1, 50);
    repeat (4) tick();
    ADDR = 3'd3;
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_txv", TX_DATA_VALID, 0);
    check("mid_rst_txd", TX_P_DATA, 0);
    check("mid_rst_irq", IRQ, 0);
    check("mid_rst_paren", PAR_EN, 0);
    check("mid_rst_partyp", PAR_TYP, 0);
    check("mid_rst_prescale", PRESCALE, 8);
    check("mid_rst_status", RDATA, 32'h06);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    clear_seen();
    repeat (40) tick();
    check("no_tx_after_rst", tx_seen.size(), 0);
    rd(3, 0, d); check("post_rst_status", d, 32'h06);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
